// File: rtl/roc_encoder_lanes_if.sv
// Image-in / AER-out bundle of the ROC encoder.
// The encoder takes the master side; the image source / AER controller takes the slave side.
interface roc_encoder_lanes_if #(
  parameter int IMAGE_SIZE = 784,
  parameter int PIXEL_BITS = 4,
  parameter int INDEX_BITS = 10
);
    logic [PIXEL_BITS-1:0] IMAGE [IMAGE_SIZE];
    logic                  NEW_IMAGE;
    logic                  AERIN_CTRL_BUSY;
    logic [INDEX_BITS-1:0] NEXT_INDEX;
    logic                  FOUND_NEXT_INDEX;
    logic                  ENCODER_RDY;
    logic [INDEX_BITS:0]   SPIKE_COUNT;

    modport master (
        input  IMAGE, NEW_IMAGE, AERIN_CTRL_BUSY,
        output NEXT_INDEX, FOUND_NEXT_INDEX, ENCODER_RDY, SPIKE_COUNT
    );

    modport slave (
        output IMAGE, NEW_IMAGE, AERIN_CTRL_BUSY,
        input  NEXT_INDEX, FOUND_NEXT_INDEX, ENCODER_RDY, SPIKE_COUNT
    );
endinterface

// File: rtl/roc_encoder_lanes.sv
// Multi-lane rank-order-coding encoder: emits pixel indices by decreasing level, ties by index.
// Optional macro ROC_TOPK_EN stops encoding after MAX_SPIKES accepted spikes.
module roc_encoder_lane #(
    parameter int PIXEL_BITS = 4,
    parameter int PW         = 4,
    parameter int IMAGE_SIZE = 784
) (
    input  logic [PIXEL_BITS-1:0] pix,
    input  logic [PIXEL_BITS-1:0] level,
    input  logic [PW-1:0]         idx,
    output logic                  hit
);
    assign hit = (idx < PW'(IMAGE_SIZE)) && (pix == level);
endmodule

module roc_encoder_lanes #(
    parameter int IMAGE_SIZE = 784,
    parameter int PIXEL_BITS = 4,
    parameter int LANES      = 4,
    parameter int MIN_LEVEL  = 1,
    parameter int INDEX_BITS = 10,
    parameter int MAX_SPIKES = 64
) (
    input logic               CLK,
    input logic               RST,
    roc_encoder_lanes_if.master bus
);
    localparam int PW = $clog2(IMAGE_SIZE + LANES + 1);
    localparam int AW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = INDEX_BITS + 1;
    localparam logic [PIXEL_BITS-1:0] MAX_LVL = {PIXEL_BITS{1'b1}};
    localparam logic [PIXEL_BITS-1:0] MIN_LVL = PIXEL_BITS'(MIN_LEVEL);
`ifdef ROC_TOPK_EN
    localparam bit TOPK = 1'b1;
`else
    localparam bit TOPK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SCAN, EMIT, WAIT_BUSY, WAIT_FREE, DONE} state_t;

    state_t                state;
    logic [PIXEL_BITS-1:0] img [IMAGE_SIZE];
    logic [PIXEL_BITS-1:0] level;
    logic [PW-1:0]         ptr;
    logic [INDEX_BITS-1:0] next_index;
    logic                  found;
    logic                  rdy;
    logic [CW-1:0]         spike_count;

    logic [LANES-1:0][PIXEL_BITS-1:0] win_pix;
    logic [LANES-1:0][PW-1:0]         win_idx;
    logic [LANES-1:0]                 hit;
    logic                             hit_any;
    logic [LW-1:0]                    hit_off;
    logic [PW-1:0]                    hit_idx;
    logic                             end_win;
    logic                             cap_reached;

    // Out-of-range lanes read zero and are masked again inside the lane compare.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign win_idx[l] = ptr + PW'(l);
        assign win_pix[l] = (win_idx[l] < PW'(IMAGE_SIZE)) ? img[win_idx[l][AW-1:0]] : '0;
        roc_encoder_lane #(.PIXEL_BITS(PIXEL_BITS), .PW(PW), .IMAGE_SIZE(IMAGE_SIZE)) u_lane (
            .pix  (win_pix[l]),
            .level(level),
            .idx  (win_idx[l]),
            .hit  (hit[l])
        );
    end

    always_comb begin
        hit_any = 1'b0;
        hit_off = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (hit[l]) begin
                hit_any = 1'b1;
                hit_off = LW'(l);
            end
        end
    end

    assign hit_idx     = ptr + PW'(hit_off);
    assign end_win     = (ptr + PW'(LANES)) >= PW'(IMAGE_SIZE);
    assign cap_reached = TOPK && (spike_count == CW'(MAX_SPIKES));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            level       <= MAX_LVL;
            ptr         <= '0;
            next_index  <= '0;
            found       <= 1'b0;
            rdy         <= 1'b1;
            spike_count <= '0;
            for (int i = 0; i < IMAGE_SIZE; i++) img[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.NEW_IMAGE) begin
                        img         <= bus.IMAGE;
                        level       <= MAX_LVL;
                        ptr         <= '0;
                        spike_count <= '0;
                        rdy         <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_any) begin
                        next_index <= INDEX_BITS'(hit_idx);
                        ptr        <= hit_idx + PW'(1);
                        state      <= EMIT;
                    end else if (!end_win) begin
                        ptr <= ptr + PW'(LANES);
                    end else begin
                        // End of a level pass: the lowest level ends the image.
                        ptr <= '0;
                        if (level <= MIN_LVL) begin
                            rdy   <= 1'b1;
                            state <= DONE;
                        end else begin
                            level <= level - PIXEL_BITS'(1);
                        end
                    end
                end
                EMIT: begin
                    found <= 1'b1;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.AERIN_CTRL_BUSY) begin
                        found       <= 1'b0;
                        spike_count <= spike_count + CW'(1);
                        state       <= WAIT_FREE;
                    end
                end
                WAIT_FREE: begin
                    if (!bus.AERIN_CTRL_BUSY) begin
                        if (cap_reached) begin
                            rdy   <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.NEXT_INDEX       = next_index;
    assign bus.FOUND_NEXT_INDEX = found;
    assign bus.ENCODER_RDY      = rdy;
    assign bus.SPIKE_COUNT      = spike_count;
endmodule

// File: tb/tb_roc_encoder_lanes.sv
// Directed bench: three encoders (LANES 4,1,7) on a 7-pixel image, each with its own AER model.
// Expected index orders and cycle counts are hand-derived from the image contents.
module tb_roc_encoder_lanes;
`ifdef ROC_TOPK_EN
    localparam int N_EXP = 3;
    localparam int STALL = 2;
    localparam int CYC_A [3] = '{31, 73, 23};
`else
    localparam int N_EXP = 6;
    localparam int STALL = 3;
    localparam int CYC_A [3] = '{59, 130, 45};
`endif
    localparam int CYC_Z [3] = '{30, 105, 15};
    localparam int EXP_SEQ [6] = '{1, 3, 4, 0, 5, 6};

    logic       clk;
    logic       rst_n;
    logic       new_image;
    logic [3:0] image [7];
    int         hold_len;
    bit         aer_on;

    int checks = 0;
    int failures = 0;

    int run_n [3], run_cyc [3], run_viol [3], run_unst [3];
    int run_log [3][8];
    int run_idx [3], run_found [3], run_rdy [3], run_cnt [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        roc_encoder_lanes_if #(.IMAGE_SIZE(7), .PIXEL_BITS(4), .INDEX_BITS(10)) bus ();
        logic busy;
        int hcnt, n, cyc, viol, unst;
        int held;
        int idx_log [8];

        assign bus.IMAGE           = image;
        assign bus.NEW_IMAGE       = new_image;
        assign bus.AERIN_CTRL_BUSY = busy;

        roc_encoder_lanes #(
            .IMAGE_SIZE(7), .PIXEL_BITS(4), .LANES((g == 0) ? 4 : (g == 1) ? 1 : 7),
            .MIN_LEVEL(1), .INDEX_BITS(10), .MAX_SPIKES(3)
        ) dut (
            .CLK(clk),
            .RST(rst_n),
            .bus(bus)
        );

        initial begin
            busy = 1'b0; hcnt = 0; n = 0; cyc = 0; viol = 0; unst = 0; held = 0;
            for (int k = 0; k < 8; k++) idx_log[k] = -1;
        end

        // AER controller model: raise BUSY the half-cycle after a valid, hold hold_len cycles.
        always @(negedge clk) begin
            if (!rst_n) begin
                busy = 1'b0;
                hcnt = 0;
            end else begin
                if (new_image && bus.ENCODER_RDY) begin
                    n = 0; cyc = 0; viol = 0; unst = 0;
                    for (int k = 0; k < 8; k++) idx_log[k] = -1;
                end else if (!bus.ENCODER_RDY) begin
                    cyc++;
                end
                if (busy) begin
                    if (bus.FOUND_NEXT_INDEX) viol++;
                    if (int'(bus.NEXT_INDEX) != held) unst++;
                    if (hcnt >= hold_len - 1) busy = 1'b0;
                    else hcnt++;
                end else if (bus.FOUND_NEXT_INDEX && aer_on) begin
                    busy = 1'b1;
                    hcnt = 0;
                    held = int'(bus.NEXT_INDEX);
                    if (n < 8) idx_log[n] = held;
                    n++;
                end
            end
        end

        assign run_n[g]     = n;
        assign run_cyc[g]   = cyc;
        assign run_viol[g]  = viol;
        assign run_unst[g]  = unst;
        assign run_log[g]   = idx_log;
        assign run_idx[g]   = int'(bus.NEXT_INDEX);
        assign run_found[g] = int'(bus.FOUND_NEXT_INDEX);
        assign run_rdy[g]   = int'(bus.ENCODER_RDY);
        assign run_cnt[g]   = int'(bus.SPIKE_COUNT);
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic load_a();
        image = '{4'd3, 4'd15, 4'd0, 4'd15, 4'd7, 4'd3, 4'd1};
    endtask

    task automatic load_zero();
        for (int i = 0; i < 7; i++) image[i] = 4'd0;
    endtask

    task automatic pulse();
        @(posedge clk); #1 new_image = 1'b1;
        @(posedge clk); #1 new_image = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = (run_rdy[0] == 1) && (run_rdy[1] == 1) && (run_rdy[2] == 1);
        end
        chk({tag, "_done_in_time"}, int'(done), 1);
    endtask

    task automatic check_run(input string tag, input int g, input int n_exp, input int exp_cyc);
        chk($sformatf("%s_l%0d_nspikes", tag, g), run_n[g], n_exp);
        for (int k = 0; k < n_exp; k++)
            chk($sformatf("%s_l%0d_idx%0d", tag, g, k), run_log[g][k], EXP_SEQ[k]);
        chk($sformatf("%s_l%0d_spike_count", tag, g), run_cnt[g], n_exp);
        chk($sformatf("%s_l%0d_found_low", tag, g), run_found[g], 0);
        if (exp_cyc >= 0)
            chk($sformatf("%s_l%0d_busy_cycles", tag, g), run_cyc[g], exp_cyc);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_l%0d_next_index", tag, g), run_idx[g], 0);
            chk($sformatf("%s_l%0d_found", tag, g), run_found[g], 0);
            chk($sformatf("%s_l%0d_rdy", tag, g), run_rdy[g], 1);
            chk($sformatf("%s_l%0d_count", tag, g), run_cnt[g], 0);
        end
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; new_image = 1'b0; hold_len = 2; aer_on = 1'b1;
        load_zero();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reference image through all three lane widths
        load_a();
        pulse();
        wait_done("img_a", 400);
        for (int g = 0; g < 3; g++) check_run("img_a", g, N_EXP, CYC_A[g]);

        // All-zero image: every level passes with no spike
        load_zero();
        pulse();
        wait_done("zero", 400);
        for (int g = 0; g < 3; g++) check_run("zero", g, 0, CYC_Z[g]);

        // Long BUSY: index must stay put and no new valid while busy
        hold_len = 20;
        load_a();
        pulse();
        wait_done("long_busy", 3000);
        for (int g = 0; g < 3; g++) begin
            check_run("long_busy", g, N_EXP, -1);
            chk($sformatf("long_busy_l%0d_valid_while_busy", g), run_viol[g], 0);
            chk($sformatf("long_busy_l%0d_index_unstable", g), run_unst[g], 0);
        end

        // Mid-encode NEW_IMAGE is ignored; reset in WAIT_BUSY drops the spike
        hold_len = 2;
        load_a();
        pulse();
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = (run_n[0] >= 1);
        end
        chk("mid_first_spike_seen", int'(seen), 1);
        load_zero();
        pulse();
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = (run_n[0] >= STALL);
        end
        chk("mid_stall_point_seen", int'(seen), 1);
        aer_on = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = (run_found[0] == 1);
        end
        chk("mid_valid_seen", int'(seen), 1);
        repeat (3) @(negedge clk);
        chk("mid_pending_index", run_idx[0], EXP_SEQ[STALL]);
        chk("mid_valid_held", run_found[0], 1);
        chk("mid_count_before_rst", run_cnt[0], STALL);
        chk("mid_rdy_low", run_rdy[0], 0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        aer_on = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_no_spike", run_n[0], STALL);
        chk("post_rst_found", run_found[0], 0);
        chk("post_rst_rdy", run_rdy[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
